// File: rtl/multiword_adder_ctrl.sv
// -----------------------------------------------------------------------------
// multiword_adder_ctrl
//
// Purpose:
//   Performs a (8*WORDS)-bit addition A + B + cin by time-multiplexing a single
//   registered 8-bit adder (sync_adder), one byte per cycle, LSB first. The
//   carry is chained between bytes through the adder's own registered cout.
//   Operands arrive on a valid/ready handshake; the wide result leaves on a
//   valid/ready handshake. Operations never overlap.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous, active-high reset
//   in_valid  in   a, b, cin are valid
//   in_ready  out  controller is idle and will accept an operation
//   a, b      in   W-bit operands (W = 8*WORDS)
//   cin       in   carry into byte 0
//   out_valid out  sum/cout valid (held until out_ready)
//   out_ready in   consumer takes the result
//   sum       out  W-bit registered sum
//   cout      out  registered carry out of the top byte
//   busy      out  high whenever the controller is not idle
// -----------------------------------------------------------------------------

// Registered 8-bit adder: s/cout appear one clock after a/b/cin. No reset.
module sync_adder (
  input  logic       clk,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);

  always_ff @(posedge clk) begin
    {cout, s} <= {1'b0, a} + {1'b0, b} + {8'd0, cin};
  end

endmodule

module multiword_adder_ctrl #(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*WORDS-1:0]   a,
  input  logic [8*WORDS-1:0]   b,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*WORDS-1:0]   sum,
  output logic                 cout,
  output logic                 busy
);

  // A 1-bit index is kept even for WORDS=1 so the counter always exists.
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;

  logic [WORDS-1:0][7:0]   r_a;
  logic [WORDS-1:0][7:0]   r_b;
  logic                    r_cin;
  logic [IDX_W-1:0]        r_idx;
  logic [IDX_W-1:0]        w_prev_idx;
  logic [WORDS-1:0][7:0]   r_sum;
  logic                    r_cout;

  logic [7:0]              w_add_a;
  logic [7:0]              w_add_b;
  logic                    w_add_cin;
  logic [7:0]              w_add_s;
  logic                    w_add_cout;

  sync_adder u_adder (
    .clk  (clk),
    .a    (w_add_a),
    .b    (w_add_b),
    .cin  (w_add_cin),
    .s    (w_add_s),
    .cout (w_add_cout)
  );

  // The adder result visible during RUN belongs to the byte issued one cycle
  // earlier, so it is written at the previous index.
  assign w_prev_idx = r_idx - IDX_W'(1);

  // Next-state and adder operand selection.
  always_comb begin
    w_state_next = r_state;
    w_add_a      = 8'd0;
    w_add_b      = 8'd0;
    w_add_cin    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        w_add_a   = r_a[r_idx];
        w_add_b   = r_b[r_idx];
        // Byte 0 takes the operand carry; later bytes take the carry the
        // adder registered for the byte below. The stale adder cout from
        // before the operation is therefore never consumed.
        w_add_cin = (r_idx == '0) ? r_cin : w_add_cout;
        if (r_idx == LAST_IDX) w_state_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        w_state_next = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_cin   <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a   <= a;
            r_b   <= b;
            r_cin <= cin;
            r_idx <= '0;
          end
        end
        ST_RUN: begin
          if (r_idx != '0) r_sum[w_prev_idx] <= w_add_s;
          r_idx <= r_idx + IDX_W'(1);
        end
        ST_FLUSH: begin
          r_sum[WORDS-1] <= w_add_s;
          r_cout         <= w_add_cout;
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;

endmodule

// File: tb/tb_multiword_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multiword_adder_ctrl
//
// Purpose:
//   Directed-vector bench for multiword_adder_ctrl (WORDS=4, 100 ns clock).
//   A cycle-level reference model derived from the handshake/latency rules
//   predicts in_ready, busy, out_valid and the exact W+1-bit result; one
//   compare process checks the DUT against it at every falling edge, and
//   hand-computed literal results are checked as each result is consumed.
// -----------------------------------------------------------------------------
module tb_multiword_adder_ctrl;

  localparam int WORDS = 4;
  localparam int W     = 8 * WORDS;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  multiword_adder_ctrl #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #50 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_cnt counts edges since the accept edge; the result is due after
  // WORDS+1 edges and stays until consumed.
  logic         m_armed = 1'b0;
  logic         m_idle  = 1'b1;
  logic         m_done  = 1'b0;
  int           m_cnt   = 0;
  logic [W:0]   m_exp   = '0;
  logic [W:0]   lit_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_armed <= 1'b1;
      m_idle  <= 1'b1;
      m_done  <= 1'b0;
      m_cnt   <= 0;
    end else if (m_armed) begin
      if (m_done) begin
        if (out_ready) begin
          m_done <= 1'b0;
          m_idle <= 1'b1;
        end
      end else if (!m_idle) begin
        m_cnt <= m_cnt + 1;
        if (m_cnt + 1 == WORDS + 1) m_done <= 1'b1;
      end else if (in_valid) begin
        m_idle <= 1'b0;
        m_cnt  <= 0;
        m_exp  <= {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (m_armed && !rst) begin
      chk("in_ready", {63'd0, in_ready}, {63'd0, m_idle});
      chk("busy", {63'd0, busy}, {63'd0, !m_idle});
      chk("out_valid", {63'd0, out_valid}, {63'd0, m_done});
      if (m_done) chk("model_result", 64'({cout, sum}), 64'(m_exp));
      if (out_valid && out_ready) begin
        if (lit_q.size() == 0) begin
          chk("unexpected_result", 64'd1, 64'd0);
        end else begin
          logic [W:0] e;
          e = lit_q.pop_front();
          chk("literal_result", 64'({cout, sum}), 64'(e));
          $display("TXN cyc=%0d sum=%08h cout=%0d expected=%09h", cyc, sum, cout, e);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_in_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    chk("wait_in_ready", {63'd0, in_ready}, 64'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      step();
      n++;
    end
    chk("wait_idle", {63'd0, busy}, 64'd0);
  endtask

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic tc, input logic [W:0] exp);
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    wait_in_ready();
    step();
    in_valid = 1'b0;
    lit_q.push_back(exp);
    wait_idle();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sum"}, 64'(sum), 64'd0);
    chk({tag, "_cout"}, {63'd0, cout}, 64'd0);
    chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int acc [3];
    logic [W-1:0] va [3];
    logic [W-1:0] vb [3];
    logic         vc [3];
    logic [W:0]   ve [3];

    // 1. Reset asserted mid-cycle: outputs clear without waiting for an edge.
    repeat (2) @(posedge clk);
    #20 rst = 1'b1;
    #1 chk_reset_outputs("rst1");
    step(); step();
    #20 rst = 1'b0;
    step();

    // 2. Basic add with latency measurement.
    a = 32'h1; b = 32'h1; cin = 1'b0; in_valid = 1'b1;
    wait_in_ready();
    step();
    in_valid = 1'b0;
    lit_q.push_back(33'h0_0000_0002);
    k = 0;
    while (!out_valid && k < 20) begin
      step();
      k++;
    end
    chk("latency_edges", 64'(k), 64'd5);
    wait_idle();

    // 3. Full carry ripple.
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33'h1_0000_0000);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 33'h1_8000_0000);

    // 4. Backpressure; an in_valid pulse during DONE is ignored.
    out_ready = 1'b0;
    a = 32'h0000_00FF; b = 32'h0000_0001; cin = 1'b0; in_valid = 1'b1;
    wait_in_ready();
    step();
    in_valid = 1'b0;
    lit_q.push_back(33'h0_0000_0100);
    k = 0;
    while (!out_valid && k < 20) begin
      step();
      k++;
    end
    chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
    repeat (3) step();
    a = 32'h5; b = 32'h5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (6) step();
    chk("bp_sum_held", 64'(sum), 64'h100);
    chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1;
    step();
    chk("bp_release_valid", {63'd0, out_valid}, 64'd0);
    chk("bp_release_ready", {63'd0, in_ready}, 64'd1);

    // 5. Reset while in RUN at idx=2 (byte 0 already written).
    a = 32'h0101_0101; b = 32'h0101_0101; cin = 1'b0; in_valid = 1'b1;
    wait_in_ready();
    step();
    in_valid = 1'b0;
    step(); step();
    #20 rst = 1'b1;
    #1 chk_reset_outputs("rst2");
    #20 rst = 1'b0;
    step();
    do_op(32'h1234_5678, 32'h1111_1111, 1'b0, 33'h0_2345_6789);

    // 6. Back-to-back with in_valid held high and out_ready tied high.
    va[0] = 32'h0000_007F; vb[0] = 32'h0000_0001; vc[0] = 1'b0; ve[0] = 33'h0_0000_0080;
    va[1] = 32'hFFFF_0000; vb[1] = 32'h0001_0000; vc[1] = 1'b0; ve[1] = 33'h1_0000_0000;
    va[2] = 32'h0000_0000; vb[2] = 32'h0000_0000; vc[2] = 1'b1; ve[2] = 33'h0_0000_0001;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = va[i]; b = vb[i]; cin = vc[i];
      wait_in_ready();
      step();
      acc[i] = cyc;
      lit_q.push_back(ve[i]);
    end
    in_valid = 1'b0;
    wait_idle();
    step();
    chk("b2b_gap_1", 64'(acc[1] - acc[0]), 64'd7);
    chk("b2b_gap_2", 64'(acc[2] - acc[1]), 64'd7);

    chk("results_outstanding", 64'(lit_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
